// File: rtl/uparc_lsu_sb.sv
// Load-store unit with a posted-store FIFO in front of the D-Bus.
// States: B_IDLE | bus quiet, B_STORE | head store on bus, B_LOAD | load on bus.
module uparc_lsu_sb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SB_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata,
    input  logic [2:0]              cmd,
    input  logic                    rnw,
    input  logic                    sext,
    output logic                    busy,
    output logic                    err_align,
    output logic                    err_bus,
    output logic                    sb_empty,
    output logic [ADDR_WIDTH-1:0]   o_DAddr,
    output logic                    o_DCmd,
    output logic                    o_DRnW,
    output logic [DATA_WIDTH/8-1:0] o_DBen,
    output logic [DATA_WIDTH-1:0]   o_DData,
    input  logic [DATA_WIDTH-1:0]   i_DData,
    input  logic                    i_DRdy,
    input  logic                    i_DErr
);
    localparam int BEN_WIDTH = DATA_WIDTH / 8;
    localparam int LANE_W    = $clog2(BEN_WIDTH);
    localparam int PTR_W     = $clog2(SB_DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    typedef enum logic [1:0] {B_IDLE, B_STORE, B_LOAD} state_t;

    state_t                  state_q;
    logic                    o_dcmd_q, o_drnw_q;
    logic [ADDR_WIDTH-1:0]   o_daddr_q;
    logic [BEN_WIDTH-1:0]    o_dben_q;
    logic [DATA_WIDTH-1:0]   o_ddata_q, rdata_q;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;

    logic [ADDR_WIDTH-1:0]   sb_addr_q [SB_DEPTH];
    logic [BEN_WIDTH-1:0]    sb_ben_q  [SB_DEPTH];
    logic [DATA_WIDTH-1:0]   sb_data_q [SB_DEPTH];

    logic [LANE_W-1:0]       lane;
    logic                    size_ok, align_ok, req_ok, st_req, ld_req, sb_full, push;
    logic [BEN_WIDTH-1:0]    ben_base, in_ben;
    logic [ADDR_WIDTH-1:0]   in_addr;
    logic [DATA_WIDTH-1:0]   in_data, ld_sh, ld_mask, ld_data;
    logic                    ld_sign, bus_ok, bus_err, pop, flush, ld_done;

    assign lane = addr[LANE_W-1:0];

    always_comb begin
        size_ok  = 1'b1;
        align_ok = 1'b1;
        ben_base = '0;
        case (cmd)
            3'd0: ;
            3'd1: ben_base = BEN_WIDTH'(8'h01);
            3'd2: begin ben_base = BEN_WIDTH'(8'h03); align_ok = (addr[0] == 1'b0); end
            3'd3: begin ben_base = BEN_WIDTH'(8'h0F); align_ok = (addr[1:0] == 2'b00); end
            3'd4: begin
                ben_base = BEN_WIDTH'(8'hFF);
                align_ok = (addr[2:0] == 3'b000);
                size_ok  = (DATA_WIDTH == 64);
            end
            default: size_ok = 1'b0;
        endcase
    end

    assign err_align = (cmd != 3'd0) && !(size_ok && align_ok);
    assign req_ok    = (cmd != 3'd0) && !err_align;
    assign st_req    = req_ok && !rnw;
    assign ld_req    = req_ok && rnw;
    assign sb_full   = (count_q == CNT_W'(SB_DEPTH));
    assign push      = st_req && !sb_full;
    assign in_addr   = {addr[ADDR_WIDTH-1:LANE_W], {LANE_W{1'b0}}};
    assign in_ben    = ben_base << lane;
    assign in_data   = wdata << {lane, 3'b000};

    assign bus_err = o_dcmd_q && i_DErr;
    assign bus_ok  = o_dcmd_q && i_DRdy && !i_DErr;
    assign pop     = (state_q == B_STORE) && bus_ok;
    assign flush   = (state_q == B_STORE) && bus_err;
    assign ld_done = (state_q == B_LOAD) && (bus_ok || bus_err);

    // A bus error drops every queued store, including one accepted this cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr_q[wr_ptr_q] <= in_addr;
            sb_ben_q[wr_ptr_q]  <= in_ben;
            sb_data_q[wr_ptr_q] <= in_data;
        end
    end

    always_comb begin
        ld_sh   = i_DData >> {lane, 3'b000};
        ld_mask = '1;
        ld_sign = 1'b0;
        case (cmd)
            3'd1: begin ld_mask = DATA_WIDTH'(8'hFF);         ld_sign = ld_sh[7];  end
            3'd2: begin ld_mask = DATA_WIDTH'(16'hFFFF);      ld_sign = ld_sh[15]; end
            3'd3: begin ld_mask = DATA_WIDTH'(32'hFFFF_FFFF); ld_sign = ld_sh[31]; end
            default: ;
        endcase
        ld_data = (ld_sh & ld_mask) | ((sext && ld_sign) ? ~ld_mask : '0);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // An empty FIFO with a store arriving issues that store directly next cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= B_IDLE;
            o_dcmd_q  <= 1'b0;
            o_drnw_q  <= 1'b0;
            o_daddr_q <= '0;
            o_dben_q  <= '0;
            o_ddata_q <= '0;
            rdata_q   <= '0;
        end else begin
            case (state_q)
                B_IDLE: begin
                    if (count_q != '0) begin
                        state_q   <= B_STORE;
                        o_dcmd_q  <= 1'b1;
                        o_drnw_q  <= 1'b0;
                        o_daddr_q <= sb_addr_q[rd_ptr_q];
                        o_dben_q  <= sb_ben_q[rd_ptr_q];
                        o_ddata_q <= sb_data_q[rd_ptr_q];
                    end else if (push) begin
                        state_q   <= B_STORE;
                        o_dcmd_q  <= 1'b1;
                        o_drnw_q  <= 1'b0;
                        o_daddr_q <= in_addr;
                        o_dben_q  <= in_ben;
                        o_ddata_q <= in_data;
                    end else if (ld_req) begin
                        state_q   <= B_LOAD;
                        o_dcmd_q  <= 1'b1;
                        o_drnw_q  <= 1'b1;
                        o_daddr_q <= in_addr;
                        o_dben_q  <= in_ben;
                        o_ddata_q <= '0;
                    end
                end
                B_STORE: begin
                    if (bus_ok || bus_err) begin
                        state_q  <= B_IDLE;
                        o_dcmd_q <= 1'b0;
                    end
                end
                B_LOAD: begin
                    if (ld_done) begin
                        state_q  <= B_IDLE;
                        o_dcmd_q <= 1'b0;
                        if (bus_ok) rdata_q <= ld_data;
                    end
                end
                default: state_q <= B_IDLE;
            endcase
        end
    end

    assign rdata    = (ld_done && bus_ok) ? ld_data : rdata_q;
    assign busy     = (st_req && sb_full) || (ld_req && !ld_done);
    assign err_bus  = bus_err;
    assign sb_empty = (count_q == '0) && (state_q != B_STORE);
    assign o_DCmd   = o_dcmd_q;
    assign o_DRnW   = o_drnw_q;
    assign o_DAddr  = o_daddr_q;
    assign o_DBen   = o_dben_q;
    assign o_DData  = o_ddata_q;
endmodule

// File: tb/tb_uparc_lsu_sb.sv
// Self-checking bench: directed vectors on 32- and 64-bit builds plus a random run against a queue model.
module tb_uparc_lsu_sb;
    localparam int DW = 32;
    localparam int SBD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic nrst;

    logic [31:0] addr, wdata, rdata, d_addr, d_wdata, i_ddata;
    logic [2:0]  cmd;
    logic        rnw, sext, busy, err_align, err_bus, sb_empty, d_cmd, d_rnw, i_drdy, i_derr;
    logic [3:0]  d_ben;

    logic [31:0] w_addr, w_d_addr;
    logic [63:0] w_wdata, w_rdata, w_d_wdata, w_i_ddata;
    logic [2:0]  w_cmd;
    logic        w_rnw, w_sext, w_busy, w_err_align, w_err_bus, w_sb_empty, w_d_cmd, w_d_rnw, w_i_drdy, w_i_derr;
    logic [7:0]  w_d_ben;

    uparc_lsu_sb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SB_DEPTH(SBD)) dut (
        .clk(clk), .nrst(nrst), .addr(addr), .wdata(wdata), .rdata(rdata), .cmd(cmd), .rnw(rnw),
        .sext(sext), .busy(busy), .err_align(err_align), .err_bus(err_bus), .sb_empty(sb_empty),
        .o_DAddr(d_addr), .o_DCmd(d_cmd), .o_DRnW(d_rnw), .o_DBen(d_ben), .o_DData(d_wdata),
        .i_DData(i_ddata), .i_DRdy(i_drdy), .i_DErr(i_derr));

    uparc_lsu_sb #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .SB_DEPTH(SBD)) dut64 (
        .clk(clk), .nrst(nrst), .addr(w_addr), .wdata(w_wdata), .rdata(w_rdata), .cmd(w_cmd), .rnw(w_rnw),
        .sext(w_sext), .busy(w_busy), .err_align(w_err_align), .err_bus(w_err_bus), .sb_empty(w_sb_empty),
        .o_DAddr(w_d_addr), .o_DCmd(w_d_cmd), .o_DRnW(w_d_rnw), .o_DBen(w_d_ben), .o_DData(w_d_wdata),
        .i_DData(w_i_ddata), .i_DRdy(w_i_drdy), .i_DErr(w_i_derr));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference rules, written as plain arithmetic on byte counts.
    function automatic longint unsigned f_dmask(int dw);
        return (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction
    function automatic bit f_err(int dw, int c, longint unsigned a);
        if (c == 0) return 1'b0;
        if (c > 4 || (c == 4 && dw == 32)) return 1'b1;
        return (a % (64'd1 << (c - 1))) != 0;
    endfunction
    function automatic longint unsigned f_ben(int dw, int c, longint unsigned a);
        int nb = 1 << (c - 1);
        return ((64'd1 << nb) - 1) << (a % (dw / 8));
    endfunction
    function automatic longint unsigned f_wd(int dw, longint unsigned a, longint unsigned d);
        return (d << (8 * (a % (dw / 8)))) & f_dmask(dw);
    endfunction
    function automatic longint unsigned f_ld(int dw, int c, longint unsigned a, bit s, longint unsigned d);
        int bits = 8 << (c - 1);
        longint unsigned m = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 1);
        longint unsigned v = (d >> (8 * (a % (dw / 8)))) & m;
        if (s && bits < dw && ((v >> (bits - 1)) & 1) == 1) v = v | ~m;
        return v & f_dmask(dw);
    endfunction

    task automatic apply_reset();
        nrst = 1'b0;
        cmd = 0; addr = 0; wdata = 0; rnw = 0; sext = 0; i_ddata = 0; i_drdy = 0; i_derr = 0;
        w_cmd = 0; w_addr = 0; w_wdata = 0; w_rnw = 0; w_sext = 0; w_i_ddata = 0; w_i_drdy = 0; w_i_derr = 0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic load32(input logic [2:0] c, input logic [31:0] a, input logic s,
                          input logic [31:0] bus_d, input logic [31:0] exp, input string nm);
        bit seen = 1'b0;
        @(negedge clk);
        cmd = c; addr = a; rnw = 1'b1; sext = s; i_drdy = 1'b0; i_derr = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (d_cmd) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        chk({nm, " issue"}, seen, 1);
        chk({nm, " addr"}, d_addr, a & 32'hFFFF_FFFC);
        i_ddata = bus_d; i_drdy = 1'b1;
        #1;
        chk({nm, " busy"}, busy, 0);
        chk({nm, " rdata"}, rdata, exp);
        @(negedge clk);
        cmd = 0; rnw = 0; i_drdy = 1'b0;
        #1;
        chk({nm, " latched"}, rdata, exp);
    endtask

    typedef struct {
        logic [2:0] c; logic [31:0] a; logic [31:0] wd; logic e;
        logic [31:0] da; logic [3:0] ben; logic [31:0] dd;
    } vec_t;
    vec_t tv[9];

    typedef struct {
        logic [2:0] c; logic [31:0] a; logic s; logic [63:0] bd; logic [63:0] exp; logic [7:0] ben;
    } ld64_t;
    ld64_t l64[4];

    typedef struct { longint unsigned a; longint unsigned b; longint unsigned d; } ent_t;
    ent_t mq[$];

    bit hold, legal, e_busy, p_cmd, p_done;
    longint unsigned p_sig, p_wd, last_rd, e_rd;
    int sel, idx, quiet;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{3'd1, 32'h1003, 32'h0000_00A5, 1'b0, 32'h1000, 4'b1000, 32'hA500_0000};
        tv[1] = '{3'd2, 32'h1002, 32'h0000_BEEF, 1'b0, 32'h1000, 4'b1100, 32'hBEEF_0000};
        tv[2] = '{3'd2, 32'h1001, 32'h0000_1234, 1'b1, 32'h0,    4'b0000, 32'h0};
        tv[3] = '{3'd3, 32'h2004, 32'hDEAD_BEEF, 1'b0, 32'h2004, 4'b1111, 32'hDEAD_BEEF};
        tv[4] = '{3'd3, 32'h2006, 32'h1111_1111, 1'b1, 32'h0,    4'b0000, 32'h0};
        tv[5] = '{3'd4, 32'h2000, 32'h2222_2222, 1'b1, 32'h0,    4'b0000, 32'h0};
        tv[6] = '{3'd5, 32'h0000, 32'h3333_3333, 1'b1, 32'h0,    4'b0000, 32'h0};
        tv[7] = '{3'd1, 32'h4001, 32'h0000_003C, 1'b0, 32'h4000, 4'b0010, 32'h0000_3C00};
        tv[8] = '{3'd2, 32'h4000, 32'h0000_7777, 1'b0, 32'h4000, 4'b0011, 32'h0000_7777};
        l64[0] = '{3'd4, 32'h08, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 8'hFF};
        l64[1] = '{3'd3, 32'h0C, 1'b1, 64'h8000_0000_1234_5678, 64'hFFFF_FFFF_8000_0000, 8'hF0};
        l64[2] = '{3'd3, 32'h10, 1'b1, 64'h0000_0000_F000_0001, 64'hFFFF_FFFF_F000_0001, 8'h0F};
        l64[3] = '{3'd1, 32'h17, 1'b0, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00AB, 8'h80};

        apply_reset();
        nrst = 1'b0;
        #1;
        chk("reset dcmd", d_cmd, 0);
        chk("reset bus", {d_addr, d_ben, d_wdata}, 0);
        chk("reset status", {busy, err_bus, sb_empty, rdata}, 33'h1_0000_0000);
        chk("reset 64", {w_d_cmd, w_busy, w_sb_empty, w_rdata}, {3'b001, 64'h0});
        @(negedge clk);
        nrst = 1'b1;

        // store vectors: lane placement and alignment errors
        foreach (tv[i]) begin
            @(negedge clk);
            cmd = tv[i].c; addr = tv[i].a; wdata = tv[i].wd; rnw = 1'b0;
            #1;
            chk($sformatf("vec%0d err_align", i), err_align, tv[i].e);
            chk($sformatf("vec%0d busy", i), busy, 0);
            @(negedge clk);
            cmd = 0;
            #1;
            chk($sformatf("vec%0d dcmd", i), d_cmd, !tv[i].e);
            if (!tv[i].e) begin
                chk($sformatf("vec%0d req", i), {d_rnw, d_addr, d_ben, d_wdata}, {1'b0, tv[i].da, tv[i].ben, tv[i].dd});
                @(negedge clk);
                #1;
                chk($sformatf("vec%0d hold", i), {d_cmd, d_addr, d_ben, d_wdata}, {1'b1, tv[i].da, tv[i].ben, tv[i].dd});
                i_drdy = 1'b1;
                @(negedge clk);
                i_drdy = 1'b0;
                #1;
                chk($sformatf("vec%0d done", i), {d_cmd, sb_empty}, 2'b01);
            end
        end

        // fill the buffer, fifth store stalls until a slot is really free
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmd = 3; addr = 32'h100 + 4 * i; wdata = 32'h1000 + i; rnw = 0; i_drdy = 0;
            #1;
            chk($sformatf("fill busy%0d", i), busy, (i == 4));
        end
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("fill stall", {busy, d_cmd, d_addr}, {2'b11, 32'h100});
        end
        @(negedge clk);
        i_drdy = 1'b1;
        #1;
        chk("fill pop same cycle", {busy, d_addr, d_wdata}, {1'b1, 32'h100, 32'h1000});
        @(negedge clk);
        i_drdy = 1'b0;
        #1;
        chk("fill accept", busy, 0);
        idx = 1;
        for (int k = 0; k < 40 && idx < 5; k++) begin
            @(negedge clk);
            cmd = 0; i_drdy = 1'b1;
            #1;
            if (d_cmd) begin
                chk($sformatf("fill order%0d", idx), {d_addr, d_wdata}, {32'h100 + 32'(4 * idx), 32'h1000 + 32'(idx)});
                idx++;
            end
        end
        chk("fill drained", idx, 5);
        @(negedge clk);
        i_drdy = 1'b0;
        #1;
        chk("fill empty", sb_empty, 1);

        // load waits behind a posted store
        apply_reset();
        @(negedge clk);
        cmd = 3; addr = 32'h2000; wdata = 32'h1122_3344; rnw = 0;
        #1;
        chk("order st busy", busy, 0);
        @(negedge clk);
        addr = 32'h3000; rnw = 1;
        #1;
        chk("order ld wait", {busy, d_cmd, d_rnw, d_addr}, {3'b110, 32'h2000});
        @(negedge clk);
        i_drdy = 1'b1;
        #1;
        chk("order st rdy", busy, 1);
        @(negedge clk);
        i_drdy = 1'b0;
        #1;
        chk("order gap", {busy, d_cmd}, 2'b10);
        @(negedge clk);
        #1;
        chk("order ld req", {d_cmd, d_rnw, d_addr}, {2'b11, 32'h3000});
        i_ddata = 32'hCAFE_F00D; i_drdy = 1'b1;
        #1;
        chk("order ld done", {busy, rdata}, {1'b0, 32'hCAFE_F00D});
        @(negedge clk);
        cmd = 0; i_drdy = 1'b0;
        #1;
        chk("order ld latched", rdata, 32'hCAFE_F00D);

        // extension
        load32(3'd2, 32'h12, 1'b1, 32'h8001_1234, 32'hFFFF_8001, "ld h sx");
        load32(3'd2, 32'h12, 1'b0, 32'h8001_1234, 32'h0000_8001, "ld h zx");
        load32(3'd1, 32'h13, 1'b1, 32'h8001_1234, 32'hFFFF_FF80, "ld b sx");
        load32(3'd1, 32'h11, 1'b1, 32'h0000_5A00, 32'h0000_005A, "ld b pos");
        load32(3'd3, 32'h20, 1'b1, 32'h9000_0001, 32'h9000_0001, "ld w");

        // misaligned load, then bus error flushes the queue
        apply_reset();
        @(negedge clk);
        cmd = 3; addr = 32'h2; rnw = 1;
        #1;
        chk("mis ld", {err_align, busy}, 2'b10);
        @(negedge clk);
        cmd = 0;
        #1;
        chk("mis ld nocmd", d_cmd, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmd = 1; addr = 32'h40 + i; wdata = i; rnw = 0;
            #1;
            chk($sformatf("flush st%0d", i), busy, 0);
        end
        @(negedge clk);
        cmd = 0; i_derr = 1'b1;
        #1;
        chk("flush err_bus", {d_cmd, err_bus}, 2'b11);
        @(negedge clk);
        i_derr = 1'b0;
        #1;
        chk("flush after", {err_bus, sb_empty}, 2'b01);
        quiet = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (d_cmd) quiet++;
        end
        chk("flush quiet", quiet, 0);

        // reset during a transfer
        @(negedge clk);
        cmd = 3; addr = 32'h500; rnw = 0;
        @(negedge clk);
        cmd = 0;
        #1;
        chk("rst mid cmd", d_cmd, 1);
        nrst = 1'b0;
        #1;
        chk("rst mid drop", {d_cmd, sb_empty}, 2'b01);
        @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst mid quiet", {d_cmd, sb_empty}, 2'b01);

        // 64-bit build
        foreach (l64[i]) begin
            @(negedge clk);
            w_cmd = l64[i].c; w_addr = l64[i].a; w_rnw = 1; w_sext = l64[i].s;
            #1;
            chk($sformatf("l64_%0d wait", i), {w_err_align, w_busy}, 2'b01);
            @(negedge clk);
            #1;
            chk($sformatf("l64_%0d req", i), {w_d_cmd, w_d_rnw, w_d_addr, w_d_ben},
                {2'b11, l64[i].a & 32'hFFFF_FFF8, l64[i].ben});
            w_i_ddata = l64[i].bd; w_i_drdy = 1'b1;
            #1;
            chk($sformatf("l64_%0d rdata", i), w_rdata, l64[i].exp);
            @(negedge clk);
            w_cmd = 0; w_rnw = 0; w_i_drdy = 1'b0;
        end
        @(negedge clk);
        w_cmd = 4; w_addr = 32'h4; w_rnw = 1;
        #1;
        chk("l64 mis dword", {w_err_align, w_busy}, 2'b10);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            w_rnw = 0;
            w_cmd = (i == 0) ? 3'd4 : 3'd1;
            w_addr = (i == 0) ? 32'h18 : 32'h15;
            w_wdata = (i == 0) ? 64'h1122_3344_5566_7788 : 64'h5A;
            @(negedge clk);
            w_cmd = 0;
            #1;
            chk($sformatf("s64_%0d req", i), {w_d_cmd, w_d_addr, w_d_ben},
                (i == 0) ? {1'b1, 32'h18, 8'hFF} : {1'b1, 32'h10, 8'h20});
            chk($sformatf("s64_%0d data", i), w_d_wdata,
                (i == 0) ? 64'h1122_3344_5566_7788 : 64'h0000_5A00_0000_0000);
            w_i_drdy = 1'b1;
            @(negedge clk);
            w_i_drdy = 1'b0;
        end

        // random traffic against a queue-of-stores model
        apply_reset();
        mq.delete();
        hold = 0; p_cmd = 0; p_done = 0; p_sig = 0; p_wd = 0; last_rd = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            if (!hold) begin
                sel = $urandom_range(0, 9);
                cmd = 3'($urandom_range(1, 3));
                rnw = (sel >= 7);
                addr = $urandom_range(0, 63) & ~((32'd1 << (cmd - 1)) - 1);
                wdata = $urandom; sext = 1'($urandom_range(0, 1));
                if (sel <= 1) cmd = 0;
                if (sel == 9) begin
                    cmd = 3'($urandom_range(0, 7)); addr = $urandom_range(0, 63); rnw = 1'($urandom_range(0, 1));
                end
            end
            i_drdy = ($urandom_range(0, 2) != 0);
            i_derr = ($urandom_range(0, 19) == 0);
            i_ddata = $urandom;
            #1;
            chk("rnd err_align", err_align, f_err(DW, int'(cmd), addr));
            chk("rnd sb_empty", sb_empty, (mq.size() == 0));
            chk("rnd err_bus", err_bus, d_cmd && i_derr);
            if (p_cmd && !p_done) begin
                chk("rnd hold", {d_cmd, d_rnw, d_ben, d_addr}, p_sig);
                chk("rnd hold data", d_wdata, p_wd);
            end
            legal = (cmd != 0) && !f_err(DW, int'(cmd), addr);
            if (d_cmd && d_rnw && !p_cmd)
                chk("rnd ld_issue", {legal && rnw, mq.size() == 0, d_addr, d_ben},
                    {2'b11, addr & 32'hFFFF_FFFC, 4'(f_ben(DW, int'(cmd), addr))});
            chk("rnd st_req pending", d_cmd && !d_rnw && mq.size() == 0, 0);
            if (d_cmd && !d_rnw && mq.size() > 0)
                chk("rnd st_req", {d_addr, d_ben, d_wdata}, {mq[0].a[31:0], mq[0].b[3:0], mq[0].d[31:0]});
            e_rd = last_rd;
            if (d_cmd && d_rnw && i_drdy && !i_derr) e_rd = f_ld(DW, int'(cmd), addr, sext, i_ddata);
            chk("rnd rdata", rdata, e_rd);
            last_rd = e_rd;
            e_busy = 1'b0;
            if (legal && !rnw) e_busy = (mq.size() == SBD);
            if (legal && rnw) e_busy = !(d_cmd && d_rnw && (i_drdy || i_derr));
            chk("rnd busy", busy, e_busy);
            if (legal && !rnw && !e_busy)
                mq.push_back('{longint'(addr & 32'hFFFF_FFFC), f_ben(DW, int'(cmd), addr), f_wd(DW, addr, wdata)});
            if (d_cmd && !d_rnw && i_derr) mq.delete();
            else if (d_cmd && !d_rnw && i_drdy && mq.size() > 0) void'(mq.pop_front());
            hold = legal && e_busy;
            p_cmd = d_cmd;
            p_done = d_cmd && (i_drdy || i_derr);
            p_sig = {d_cmd, d_rnw, d_ben, d_addr};
            p_wd = d_wdata;
        end
        cmd = 0; i_derr = 1'b0; i_drdy = 1'b1;
        for (int k = 0; k < 40 && !sb_empty; k++) begin
            @(negedge clk);
            #1;
        end
        chk("rnd drain", sb_empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uparc_lsu_sb.md
Name: uparc_lsu_sb

Overview:
Second-generation load-store unit. It is parametrised in address and data width (32- or 64-bit D-Bus) and adds a posted-store buffer, so stores retire without stalling the pipeline. It also adds sign-extending loads and registered, held D-Bus requests. It sits between the CPU execute/memory stage and the D-Bus, and keeps the existing D-Bus signal set.

Parameters:
ADDR_WIDTH, 32, address bus width.
DATA_WIDTH, 32, data bus width; legal values 32 or 64. BEN_WIDTH = DATA_WIDTH/8.
SB_DEPTH, 4, store buffer entries; power of 2, at least 2.

Ports:
clk  in  1  clock, rising edge.
nrst  in  1  asynchronous active-low reset.
addr  in  ADDR_WIDTH  access byte address.
wdata  in  DATA_WIDTH  store data, right-aligned.
rdata  out  DATA_WIDTH  load result, right-aligned, extended per sext.
cmd  in  3  access size: 0 idle, 1 byte, 2 hword, 3 word, 4 dword (legal only when DATA_WIDTH=64); 5-7 illegal.
rnw  in  1  1 = load, 0 = store.
sext  in  1  load sign-extend enable.
busy  out  1  request not completed this cycle; the CPU holds its inputs.
err_align  out  1  misaligned or illegal access (combinational).
err_bus  out  1  bus error pulse.
sb_empty  out  1  store buffer empty and no store in flight.
o_DAddr  out  ADDR_WIDTH  bus address, aligned to DATA_WIDTH/8.
o_DCmd  out  1  bus request valid.
o_DRnW  out  1  bus read/not-write.
o_DBen  out  BEN_WIDTH  byte enables.
o_DData  out  DATA_WIDTH  lane-positioned write data.
i_DData  in  DATA_WIDTH  read data.
i_DRdy  in  1  transfer complete.
i_DErr  in  1  transfer error.

Behaviour:
- Clock and reset: one clock (clk); asynchronous active-low reset (nrst).
- Reset values: all bus outputs 0, rdata 0, busy 0, err_bus 0, sb_empty 1, buffer pointers and count 0, FSM in B_IDLE. Assertion mid-transfer drops o_DCmd immediately and discards all buffered stores.
- Alignment: hword needs addr[0]=0, word needs addr[1:0]=0, dword needs addr[2:0]=0. Illegal cmd values also raise err_align. When err_align=1 the request is ignored and busy=0.
- Lane mapping: lane = addr[log2(BEN_WIDTH)-1:0]. o_DBen is contiguous ones of access size shifted to the lane, and write data is shifted by lane*8.
- Store (rnw=0): accepted in the cycle count<SB_DEPTH, sampled at the cycle start. A pop in the same cycle does not free a slot. On acceptance busy=0, and {aligned addr, ben, shifted data} is pushed. When the buffer is full, busy=1.
- Load (rnw=1): issued only when the buffer is empty, no store is in flight and the FSM is in B_IDLE. busy=1 until the response cycle.
- FSM states: B_IDLE, B_STORE, B_LOAD.
- B_IDLE → B_STORE: when count>0. Bus outputs are registered from the head entry; o_DCmd=1 from the next cycle.
- B_IDLE → B_LOAD: when a load is pending and the buffer is empty. Stores have priority over loads.
- Request hold: o_DCmd, o_DAddr, o_DBen, o_DData and o_DRnW are held stable until i_DRdy or i_DErr. i_DRdy/i_DErr are ignored while o_DCmd=0.
- B_STORE on i_DRdy: pop; go to B_IDLE. The next store issues one cycle later, so there is one idle bus cycle between transfers.
- B_STORE on i_DErr: err_bus=1 for one cycle, the whole buffer is flushed, go to B_IDLE. i_DErr has priority over i_DRdy.
- B_LOAD on i_DRdy: busy=0 in the same cycle. rdata is driven combinationally from i_DData, extracted and extended, and latched for later cycles. Go to B_IDLE.
- B_LOAD on i_DErr: err_bus=1, busy=0, rdata keeps its previous latched value; go to B_IDLE.
- Extension: sext=1 sign-extends byte/hword, and word when DATA_WIDTH=64. Otherwise zero-extend.
- Minimum latency: a store retires to the CPU in 0 cycles. A load with an empty buffer issues o_DCmd one cycle after presentation; with a same-cycle i_DRdy it completes in 2 cycles.
- sb_empty = (count==0) && state!=B_STORE.

Test Plan:
1. DATA_WIDTH=32: store byte 0xA5 to 0x1003 → busy=0 same cycle; next cycle o_DCmd=1, o_DAddr=0x1000, o_DBen=4'b1000, o_DData=0xA5000000, held until i_DRdy.
2. Fill buffer: 5 back-to-back word stores with SB_DEPTH=4 and i_DRdy held low → 5th store sees busy=1 until the first pop; then stores drain in FIFO order.
3. Word store to 0x2000, then word load from 0x3000 → load busy until the store completes; load o_DCmd appears only after the store's i_DRdy.
4. Load hword from 0x12 with sext=1, i_DData=0x8001_xxxx → rdata=0xFFFF8001; with sext=0 → 0x00008001.
5. Misaligned word load at 0x2 → err_align=1, busy=0, no o_DCmd. Then 3 stores queued and i_DErr on the first → err_bus one cycle, sb_empty=1, no further bus requests.
6. DATA_WIDTH=64: dword load at 0x8 with i_DData=0x0123456789ABCDEF → rdata unchanged; cmd=4 when DATA_WIDTH=32 → err_align=1.
